mem_request_arbiter: RTL

// - Shares the single memory-controller request port (address/type/request/write data, memory_ready/write_complete

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_request_arbiter_if.sv | 26 ++
 rtl/rr_arbiter2.sv | 12 +
 rtl/mem_request_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and widths for the memory request arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam logic REQ_READ = 1'b0;
  localparam logic REQ_WRITE = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
endpackage

// File: rtl/mem_request_arbiter_if.sv
// mem_request_arbiter_if: requester-side and memory-controller-side signals of the arbiter
interface mem_request_arbiter_if;
  import mem_arb_pkg::*;
  logic r0_request, r0_type, r0_done, r0_err;
  logic [ADDR_W-1:0] r0_address;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic r1_request, r1_type, r1_done, r1_err;
  logic [ADDR_W-1:0] r1_address;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic request, request_type;
  logic [ADDR_W-1:0] request_address;
  logic [DATA_W-1:0] memory_write, data_out;
  logic memory_ready, write_complete, busy, grant_id;
  modport slave (
    input r0_request, r0_type, r0_address, r0_wdata, r1_request, r1_type, r1_address, r1_wdata,
    input data_out, memory_ready, write_complete,
    output r0_done, r0_err, r0_rdata, r1_done, r1_err, r1_rdata,
    output request, request_type, request_address, memory_write, busy, grant_id
  );
  modport master (
    output r0_request, r0_type, r0_address, r0_wdata, r1_request, r1_type, r1_address, r1_wdata,
    output data_out, memory_ready, write_complete,
    input r0_done, r0_err, r0_rdata, r1_done, r1_err, r1_rdata,
    input request, request_type, request_address, memory_write, busy, grant_id
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: picks the winner of two requests, round-robin or fixed priority on a tie
module rr_arbiter2 #(
  parameter bit PRIORITY_MODE = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);
  assign valid = |req;
  assign winner = (&req) ? (PRIORITY_MODE ? 1'b0 : ~last_grant) : req[1];
endmodule

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: shares the memory-controller port between two requesters with a watchdog
module mem_request_arbiter #(
  parameter bit          PRIORITY_MODE = 1'b0,
  parameter logic [15:0] TIMEOUT       = 16'hFFFF
) (
  input logic clk,
  input logic reset,
  mem_request_arbiter_if.slave bus
);
  import mem_arb_pkg::*;
  state_t state, state_n;
  logic last_grant, last_grant_n, grant, grant_n, req, req_n, req_type, req_type_n;
  logic any, win, complete, expire;
  logic [15:0] timer, timer_n;
  logic [ADDR_W-1:0] req_addr, req_addr_n;
  logic [DATA_W-1:0] req_wdata, req_wdata_n;
  logic [1:0] done, done_n, err, err_n;
  logic [DATA_W-1:0] rdata [2];
  logic [DATA_W-1:0] rdata_n [2];
  rr_arbiter2 #(.PRIORITY_MODE(PRIORITY_MODE)) u_arb (
    .req({bus.r1_request, bus.r0_request}),
    .last_grant(last_grant),
    .valid(any),
    .winner(win)
  );
  assign complete = (req_type == REQ_WRITE) ? bus.write_complete : bus.memory_ready;
  assign expire = (TIMEOUT != 16'd0) && (timer == TIMEOUT - 16'd1);
  // next-state and next values of every latched field
  always_comb begin
    state_n = state;
    last_grant_n = last_grant;
    grant_n = grant;
    req_n = req;
    req_type_n = req_type;
    req_addr_n = req_addr;
    req_wdata_n = req_wdata;
    timer_n = timer;
    done_n = done;
    err_n = err;
    rdata_n = rdata;
    case (state)
      ST_IDLE: if (any) begin
        state_n = ST_WAIT;
        req_n = 1'b1;
        grant_n = win;
        timer_n = '0;
        req_type_n = win ? bus.r1_type : bus.r0_type;
        req_addr_n = win ? bus.r1_address : bus.r0_address;
        req_wdata_n = win ? bus.r1_wdata : bus.r0_wdata;
      end
      ST_WAIT: begin
        timer_n = (&timer) ? timer : timer + 16'd1;
        if (complete || expire) begin
          state_n = ST_DONE;
          req_n = 1'b0;
          done_n[grant] = 1'b1;
          err_n[grant] = ~complete;
          if (req_type == REQ_READ) rdata_n[grant] = complete ? bus.data_out : '0;
          if (complete) last_grant_n = grant;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        done_n = '0;
        err_n = '0;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  // state and transaction registers; reset withdraws the request at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      last_grant <= 1'b1;
      grant <= 1'b0;
      req <= 1'b0;
      req_type <= 1'b0;
      req_addr <= '0;
      req_wdata <= '0;
      timer <= '0;
      done <= '0;
      err <= '0;
      rdata <= '{'0, '0};
    end else begin
      state <= state_n;
      last_grant <= last_grant_n;
      grant <= grant_n;
      req <= req_n;
      req_type <= req_type_n;
      req_addr <= req_addr_n;
      req_wdata <= req_wdata_n;
      timer <= timer_n;
      done <= done_n;
      err <= err_n;
      rdata <= rdata_n;
    end
  end
  assign bus.request = req;
  assign bus.request_type = req_type;
  assign bus.request_address = req_addr;
  assign bus.memory_write = req_wdata;
  assign bus.r0_done = done[0];
  assign bus.r1_done = done[1];
  assign bus.r0_err = err[0];
  assign bus.r1_err = err[1];
  assign bus.r0_rdata = rdata[0];
  assign bus.r1_rdata = rdata[1];
  assign bus.busy = state != ST_IDLE;
  assign bus.grant_id = grant;
endmodule
